uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Purpose : finds a run of SYNC_LEN 0xFF bytes in the UART byte stream and unpacks the 10-byte tank/bullet payload that follows.
// Latency : frame_valid and the new output fields appear 2 clk after the rx_done of the last payload byte.
// Backpressure: none; every rx_done strobe is consumed, and malformed or stalled frames are dropped and counted.
module uart_frame_decoder #(
    parameter int SYNC_LEN = 4,
    parameter int GAP_MAX  = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [9:0] xpos_tank_enemy,
    output logic [9:0] ypos_tank_enemy,
    output logic [9:0] xpos_bullet_enemy,
    output logic [9:0] ypos_bullet_enemy,
    output logic       select_mode_enemy,
    output logic [1:0] direction_tank_enemy,
    output logic [2:0] direction_for_enemy_rx,
    output logic       tank_hit_rx,
    output logic [7:0] hp_enemy,
    output logic       frame_valid,
    output logic       link_up,
    output logic [7:0] frame_err_cnt
);

    localparam int SYNC_W   = $clog2(SYNC_LEN + 1);
    localparam int GAP_W    = $clog2(GAP_MAX + 1);
    localparam int IDLE_MAX = 4 * GAP_MAX;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic [3:0]        r_idx;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    // Shadow copy of the frame under assembly; only the bits that can be
    // nonzero in a legal frame are kept.
    logic [9:0]        r_sh_x;
    logic [9:0]        r_sh_y;
    logic [9:0]        r_sh_bx;
    logic [9:0]        r_sh_by;
    logic [6:0]        r_sh_flags;
    logic [7:0]        r_sh_hp;

    // Committed, externally visible fields.
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [9:0]        r_bx;
    logic [9:0]        r_by;
    logic              r_sel;
    logic [1:0]        r_dir_tank;
    logic [2:0]        r_dir_enemy;
    logic              r_hit;
    logic [7:0]        r_hp;
    logic              r_frame_valid;
    logic              r_link_up;
    logic [7:0]        r_err_cnt;

    logic              w_byte_ff;
    logic              w_sync_done;
    logic              w_hi_byte;
    logic              w_bad_byte;
    logic              w_gap_expired;
    logic              w_abort;

    assign w_byte_ff     = (rx_data == 8'hFF);
    assign w_sync_done   = rx_done && w_byte_ff && (r_sync_cnt == SYNC_W'(SYNC_LEN - 1));
    // Odd indices below 8 carry the two MSBs of a 10-bit coordinate.
    assign w_hi_byte     = r_idx[0] && (r_idx < 4'd8);
    assign w_bad_byte    = (w_hi_byte && (|rx_data[7:2])) || ((r_idx == 4'd8) && rx_data[7]);
    assign w_gap_expired = (r_gap_cnt == GAP_W'(GAP_MAX));
    // A stalled frame is dropped even if a byte shows up in the same cycle.
    assign w_abort       = (r_state == PAYLOAD) && (w_gap_expired || (rx_done && w_bad_byte));

    // Frame FSM: sync hunt, payload capture into the shadow, atomic commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= HUNT;
            r_sync_cnt    <= '0;
            r_idx         <= 4'd0;
            r_gap_cnt     <= '0;
            r_sh_x        <= 10'd0;
            r_sh_y        <= 10'd0;
            r_sh_bx       <= 10'd0;
            r_sh_by       <= 10'd0;
            r_sh_flags    <= 7'd0;
            r_sh_hp       <= 8'd0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_bx          <= 10'd0;
            r_by          <= 10'd0;
            r_sel         <= 1'b0;
            r_dir_tank    <= 2'd0;
            r_dir_enemy   <= 3'd0;
            r_hit         <= 1'b0;
            r_hp          <= 8'd0;
            r_frame_valid <= 1'b0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                HUNT, COMMIT: begin
                    if (r_state == COMMIT) begin
                        r_x           <= r_sh_x;
                        r_y           <= r_sh_y;
                        r_bx          <= r_sh_bx;
                        r_by          <= r_sh_by;
                        r_sel         <= r_sh_flags[6];
                        r_dir_tank    <= r_sh_flags[5:4];
                        r_dir_enemy   <= r_sh_flags[3:1];
                        r_hit         <= r_sh_flags[0];
                        r_hp          <= r_sh_hp;
                        r_frame_valid <= 1'b1;
                    end
                    r_state <= HUNT;
                    // A byte landing in the commit cycle already belongs to the next hunt.
                    if (rx_done) begin
                        if (w_sync_done) begin
                            r_state    <= PAYLOAD;
                            r_sync_cnt <= '0;
                            r_idx      <= 4'd0;
                            r_gap_cnt  <= '0;
                        end else if (w_byte_ff) begin
                            r_sync_cnt <= r_sync_cnt + 1'b1;
                        end else begin
                            r_sync_cnt <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_abort) begin
                        r_state    <= HUNT;
                        r_sync_cnt <= '0;
                        r_idx      <= 4'd0;
                        r_gap_cnt  <= '0;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else if (rx_done) begin
                        r_gap_cnt <= '0;
                        case (r_idx)
                            4'd0:    r_sh_x[7:0]  <= rx_data;
                            4'd1:    r_sh_x[9:8]  <= rx_data[1:0];
                            4'd2:    r_sh_y[7:0]  <= rx_data;
                            4'd3:    r_sh_y[9:8]  <= rx_data[1:0];
                            4'd4:    r_sh_bx[7:0] <= rx_data;
                            4'd5:    r_sh_bx[9:8] <= rx_data[1:0];
                            4'd6:    r_sh_by[7:0] <= rx_data;
                            4'd7:    r_sh_by[9:8] <= rx_data[1:0];
                            4'd8:    r_sh_flags   <= rx_data[6:0];
                            4'd9:    r_sh_hp      <= rx_data;
                            default: ;
                        endcase
                        if (r_idx == 4'd9) begin
                            r_state <= COMMIT;
                            r_idx   <= 4'd0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

    // Link watchdog: raised with each commit, dropped after 4*GAP_MAX quiet cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
            r_link_up  <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_idle_cnt <= '0;
            r_link_up  <= 1'b1;
        end else if (r_link_up) begin
            if (r_idle_cnt == IDLE_W'(IDLE_MAX - 1)) begin
                r_idle_cnt <= '0;
                r_link_up  <= 1'b0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign xpos_tank_enemy        = r_x;
    assign ypos_tank_enemy        = r_y;
    assign xpos_bullet_enemy      = r_bx;
    assign ypos_bullet_enemy      = r_by;
    assign select_mode_enemy      = r_sel;
    assign direction_tank_enemy   = r_dir_tank;
    assign direction_for_enemy_rx = r_dir_enemy;
    assign tank_hit_rx            = r_hit;
    assign hp_enemy               = r_hp;
    assign frame_valid            = r_frame_valid;
    assign link_up                = r_link_up;
    assign frame_err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed vector table, multi-cycle corner sequences,
// and a random byte stream checked against a timestamped frame-parsing model.
module tb_uart_frame_decoder;

    localparam int SYNC = 4;
    localparam int GAP  = 40;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] bx;
        logic [9:0] by;
        logic       sel;
        logic [1:0] dt;
        logic [2:0] de;
        logic       hit;
        logic [7:0] hp;
    } out_t;

    typedef struct packed {
        logic [79:0] pl;   // first payload byte in the MSBs
        logic        ok;
        out_t        exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [9:0] xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy;
    logic       select_mode_enemy, tank_hit_rx, frame_valid, link_up;
    logic [1:0] direction_tank_enemy;
    logic [2:0] direction_for_enemy_rx;
    logic [7:0] hp_enemy, frame_err_cnt;

    uart_frame_decoder #(.SYNC_LEN(SYNC), .GAP_MAX(GAP)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rx_data                (rx_data),
        .rx_done                (rx_done),
        .xpos_tank_enemy        (xpos_tank_enemy),
        .ypos_tank_enemy        (ypos_tank_enemy),
        .xpos_bullet_enemy      (xpos_bullet_enemy),
        .ypos_bullet_enemy      (ypos_bullet_enemy),
        .select_mode_enemy      (select_mode_enemy),
        .direction_tank_enemy   (direction_tank_enemy),
        .direction_for_enemy_rx (direction_for_enemy_rx),
        .tank_hit_rx            (tank_hit_rx),
        .hp_enemy               (hp_enemy),
        .frame_valid            (frame_valid),
        .link_up                (link_up),
        .frame_err_cnt          (frame_err_cnt)
    );

    always #5 clk = ~clk;

    out_t cur_o;
    assign cur_o = {xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy,
                    select_mode_enemy, direction_tank_enemy, direction_for_enemy_rx,
                    tank_hit_rx, hp_enemy};

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_edge = 0;
    int   fv_count = 0;
    int   viol = 0;
    out_t prev_o;
    out_t cap_q[$];

    // Capture every committed frame and flag any output change not accompanied by frame_valid.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_valid) begin
                fv_count <= fv_count + 1;
                cap_q.push_back(cur_o);
            end else if (cur_o !== prev_o) begin
                viol <= viol + 1;
            end
        end
        prev_o <= cur_o;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic out_t mk_out(int x, int y, int bx, int by, int sel, int dt, int de, int hit, int hp);
        out_t o;
        o.x = 10'(x); o.y = 10'(y); o.bx = 10'(bx); o.by = 10'(by);
        o.sel = 1'(sel); o.dt = 2'(dt); o.de = 3'(de); o.hit = 1'(hit); o.hp = 8'(hp);
        return o;
    endfunction

    function automatic int pb(logic [79:0] pl, int i);
        logic [7:0] b;
        b = pl[79-8*i -: 8];
        return int'(b);
    endfunction

    // Field extraction straight from the documented byte layout.
    function automatic out_t decode(logic [79:0] pl);
        int f;
        f = pb(pl, 8);
        return mk_out((pb(pl,1) % 4) * 256 + pb(pl,0), (pb(pl,3) % 4) * 256 + pb(pl,2),
                      (pb(pl,5) % 4) * 256 + pb(pl,4), (pb(pl,7) % 4) * 256 + pb(pl,6),
                      (f / 64) % 2, (f / 16) % 4, (f / 2) % 8, f % 2, pb(pl,9));
    endfunction

    task automatic drive(input logic d, input logic [7:0] b);
        @(negedge clk);
        rx_done = d;
        rx_data = b;
        n_edge++;
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 8'h00);
    endtask

    task automatic send_sync();
        repeat (SYNC) send(8'hFF);
    endtask

    task automatic send_frame(input logic [79:0] pl);
        send(8'h00);
        send_sync();
        for (int i = 0; i < 10; i++) send(8'(pb(pl, i)));
    endtask

    // Reference model: consumes (edge index, byte) events and parses frames from timestamps.
    int          m_sync, m_idx, m_last, m_err;
    bit          m_open;
    logic [79:0] m_pl;
    out_t        exp_q[$];

    task automatic m_abort();
        m_open = 0;
        m_sync = 0;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_byte(input int t, input logic [7:0] b);
        bit hunt;
        hunt = 1;
        if (m_open) begin
            if (t - m_last == GAP + 1) begin
                m_abort();   // timeout fires on this very edge; the byte is lost
                return;
            end else if (t - m_last > GAP + 1) begin
                m_abort();   // timed out earlier; the byte is an ordinary hunt byte
            end else begin
                hunt = 0;
                if (((m_idx % 2 == 1) && m_idx < 8 && b > 8'd3) || (m_idx == 8 && b > 8'd127)) begin
                    m_abort();
                end else begin
                    m_pl[79-8*m_idx -: 8] = b;
                    m_idx++;
                    m_last = t;
                    if (m_idx == 10) begin
                        exp_q.push_back(decode(m_pl));
                        m_open = 0;
                    end
                end
            end
        end
        if (hunt) begin
            if (b == 8'hFF) begin
                m_sync++;
                if (m_sync == SYNC) begin
                    m_open = 1;
                    m_idx  = 0;
                    m_sync = 0;
                    m_last = t;
                end
            end else begin
                m_sync = 0;
            end
        end
    endtask

    task automatic rsend(input logic [7:0] b);
        int r, g;
        r = int'($urandom_range(0, 99));
        if (r < 95)       g = int'($urandom_range(0, 2));
        else if (r == 95) g = GAP - 1;
        else if (r == 96) g = GAP;
        else if (r == 97) g = GAP + 1;
        else              g = GAP + 4;
        idle(g);
        send(b);
        model_byte(n_edge, b);
    endtask

    vec_t vecs[7];
    out_t last_good;
    int   fv0, exp_err, kind, pos;
    logic [79:0] rpl;
    logic [7:0]  rb;

    initial begin
        vecs[0] = '{80'h2C01F000FF0310005A64, 1'b1, mk_out(300, 240, 1023, 16, 1, 1, 5, 0, 100)};
        vecs[1] = '{80'h00000000000000000000, 1'b1, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2] = '{80'h11040000000000000000, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3] = '{80'hFF03FF03FF03FF037FFF, 1'b1, mk_out(1023, 1023, 1023, 1023, 1, 3, 7, 1, 255)};
        vecs[4] = '{80'h01000200030004008005, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{80'h34027801AB00CD032507, 1'b1, mk_out(564, 376, 171, 973, 0, 2, 2, 1, 7)};
        vecs[6] = '{80'h01000200030004FC0000, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        idle(3);
        chk("reset_outputs", 64'(cur_o), 64'd0);
        chk("reset_fv_link", {62'd0, frame_valid, link_up}, 64'd0);
        chk("reset_err_cnt", 64'(frame_err_cnt), 64'd0);
        rst = 1'b1;
        idle(2);

        // Reference frame: exact frame_valid timing and link watchdog span.
        send_frame(vecs[0].pl);
        drive(1'b0, 8'h00);
        chk("commit_cycle_fv", 64'(frame_valid), 64'd0);
        drive(1'b0, 8'h00);
        chk("fv_pulse", 64'(frame_valid), 64'd1);
        chk("ref_outputs", 64'(cur_o), 64'(vecs[0].exp));
        chk("ref_link_up", 64'(link_up), 64'd1);
        drive(1'b0, 8'h00);
        chk("fv_one_cycle", 64'(frame_valid), 64'd0);
        chk("fv_count_ref", 64'(fv_count), 64'd1);
        idle(4 * GAP - 3);
        chk("link_held", 64'(link_up), 64'd1);
        idle(3);
        chk("link_dropped", 64'(link_up), 64'd0);

        // Vector table: good frames update, malformed ones count and leave outputs alone.
        last_good = vecs[0].exp;
        exp_err = 0;
        for (int i = 0; i < 7; i++) begin
            fv0 = fv_count;
            send_frame(vecs[i].pl);
            idle(4);
            if (vecs[i].ok) last_good = vecs[i].exp;
            else exp_err++;
            chk($sformatf("vec%0d_out", i), 64'(cur_o), 64'(last_good));
            chk($sformatf("vec%0d_fv", i), 64'(fv_count - fv0), vecs[i].ok ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d_err", i), 64'(frame_err_cnt), 64'(exp_err));
        end

        // Broken sync run then a good frame.
        fv0 = fv_count;
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'h00);
        send_frame(vecs[3].pl);
        idle(4);
        last_good = vecs[3].exp;
        chk("short_sync_out", 64'(cur_o), 64'(last_good));
        chk("short_sync_fv", 64'(fv_count - fv0), 64'd1);
        chk("short_sync_err", 64'(frame_err_cnt), 64'(exp_err));

        // Stalled frame times out, then a full frame decodes.
        fv0 = fv_count;
        send(8'h00); send_sync();
        send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h03);
        idle(GAP + 3);
        exp_err++;
        chk("gap_abort_err", 64'(frame_err_cnt), 64'(exp_err));
        chk("gap_abort_fv", 64'(fv_count - fv0), 64'd0);
        chk("gap_abort_out", 64'(cur_o), 64'(last_good));
        send_frame(vecs[5].pl);
        idle(4);
        last_good = vecs[5].exp;
        chk("after_gap_out", 64'(cur_o), 64'(last_good));

        // Gaps of exactly GAP_MAX cycles are tolerated.
        fv0 = fv_count;
        send(8'h00); send_sync();
        idle(GAP - 1);
        for (int i = 0; i < 10; i++) begin
            send(8'(pb(vecs[0].pl, i)));
            if (i == 4) idle(GAP - 1);
        end
        idle(4);
        last_good = vecs[0].exp;
        chk("gap_edge_fv", 64'(fv_count - fv0), 64'd1);
        chk("gap_edge_out", 64'(cur_o), 64'(last_good));
        chk("gap_edge_err", 64'(frame_err_cnt), 64'(exp_err));

        // Byte arriving on the timeout edge loses to the abort.
        fv0 = fv_count;
        send(8'h00); send_sync(); send(8'h01);
        idle(GAP);
        send(8'h00);
        idle(3);
        exp_err++;
        chk("abort_wins_err", 64'(frame_err_cnt), 64'(exp_err));
        chk("abort_wins_fv", 64'(fv_count - fv0), 64'd0);

        // Reset mid-payload clears everything; the tail and a short sync decode nothing.
        fv0 = fv_count;
        send(8'h00); send_sync();
        send(8'h34); send(8'h02); send(8'h78); send(8'h01); send(8'hAB);
        idle(1);
        rst = 1'b0;
        #1;
        chk("midrst_out", 64'(cur_o), 64'd0);
        chk("midrst_fv_link", {62'd0, frame_valid, link_up}, 64'd0);
        chk("midrst_err", 64'(frame_err_cnt), 64'd0);
        idle(1);
        rst = 1'b1;
        send(8'h00); send(8'hCD); send(8'h03); send(8'h25); send(8'h07);
        idle(2);
        send(8'hFF); send(8'hFF); send(8'hFF);
        for (int i = 0; i < 10; i++) send(8'(pb(vecs[5].pl, i)));
        idle(4);
        chk("postrst_no_fv", 64'(fv_count - fv0), 64'd0);
        chk("postrst_out", 64'(cur_o), 64'd0);
        send_frame(vecs[0].pl);
        idle(4);
        chk("postrst_frame", 64'(cur_o), 64'(vecs[0].exp));
        chk("postrst_fv", 64'(fv_count - fv0), 64'd1);

        // Error counter saturation and link timeout.
        fv0 = fv_count;
        for (int i = 0; i < 260; i++) begin
            send(8'h00); send_sync(); send(8'h2C); send(8'h04);
            idle(1);
        end
        idle(2);
        chk("err_saturate", 64'(frame_err_cnt), 64'd255);
        chk("sat_no_fv", 64'(fv_count - fv0), 64'd0);
        chk("sat_out_hold", 64'(cur_o), 64'(vecs[0].exp));
        chk("sat_link_down", 64'(link_up), 64'd0);

        // Random stream against the timestamp model.
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(2);
        cap_q.delete();
        m_sync = 0; m_idx = 0; m_last = 0; m_err = 0; m_open = 0;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 2) begin
                rpl = {$urandom, $urandom, 16'($urandom)};
                for (int i = 1; i < 8; i += 2) rpl[79-8*i -: 8] = rpl[79-8*i -: 8] & 8'h03;
                rpl[79-64 -: 8] = rpl[79-64 -: 8] & 8'h7F;
                if (kind == 2) begin
                    pos = int'($urandom_range(0, 4));
                    if (pos == 4) rpl[79-64 -: 8] = rpl[79-64 -: 8] | 8'h80;
                    else rpl[79-8*(2*pos+1) -: 8] = {6'($urandom_range(1, 63)), 2'($urandom)};
                end
                repeat (SYNC) rsend(8'hFF);
                for (int i = 0; i < 10; i++) rsend(8'(pb(rpl, i)));
            end else begin
                repeat (int'($urandom_range(1, 6))) begin
                    rb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                    rsend(rb);
                end
            end
        end
        idle(GAP + 5);
        if (m_open) m_abort();
        chk("rand_frames", 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            chk($sformatf("rand_frame%0d", i), 64'(cap_q[i]), 64'(exp_q[i]));
        chk("rand_err", 64'(frame_err_cnt), 64'(m_err));
        chk("outputs_only_on_fv", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
